// File: rtl/rc_channel_sequencer_if.sv
// Receiver bundle: raw PWM inputs in, published channel values and status out.
// Latency: none, wires only.
// Backpressure: none, every output is a level or a single-cycle pulse.
interface rc_channel_sequencer_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   pwm_in;
  logic [8*NUM_CH-1:0] ch_data;
  logic                frame_valid;
  logic                failsafe;
  logic                pulse_err;
  logic [2:0]          active_ch;

  // The sequencer consumes pulses and produces the published frame.
  modport master (
    input  pwm_in,
    output ch_data, frame_valid, failsafe, pulse_err, active_ch
  );

  // The receiver/flight-controller side drives pulses and reads the frame.
  modport slave (
    output pwm_in,
    input  ch_data, frame_valid, failsafe, pulse_err, active_ch
  );
endinterface

// File: rtl/rc_channel_sequencer.sv
// RC receiver front end: one shared tick divider and width counter measure NUM_CH PWM channels in turn.
// Latency: last falling edge to frame_valid is 5 cycles (2 sync, 1 edge, 1 store, 1 publish).
// Backpressure: none; a completed frame is published unconditionally. RC_SMOOTH_EN averages each frame with the previous one.
module rc_channel_sequencer #(
  parameter int         NUM_CH        = 4,
  parameter int         DIV           = 208,
  parameter int         OFFSET        = 256,
  parameter int         MIN_TICKS     = 128,
  parameter int         MAX_TICKS     = 1023,
  parameter int         TIMEOUT_TICKS = 6400,
  parameter logic [7:0] FAILSAFE_VAL  = 8'h00
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  rc_channel_sequencer_if.master bus
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam int WW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [CW-1:0] WIDTH_LAST = CW'(MAX_TICKS - 1);
  localparam logic [CW-1:0] WIDTH_MAX  = CW'(MAX_TICKS);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_TICKS - 1);
  localparam logic [WW-1:0] WD_MAX     = WW'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_STORE
  } state_t;

  // Input path
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;

  // Tick divider
  logic [DW-1:0] div_q;
  logic          tick;

  // Sequencer
  state_t            state_q;
  logic [2:0]        active_ch_q;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     width_q;
  logic              stuck_q;
  logic              pulse_err_q;
  logic [NUM_CH-1:0] mask_q;
  logic [7:0]        shadow_q [NUM_CH];
  logic              mask_full;

  // Grant / store decode
  logic [IW-1:0] grant_idx;
  logic          multi_rise;
  logic [31:0]   width_ext;
  logic [7:0]    value_d;
  logic          store_ok_d;

  // Publish / watchdog
  logic [8*NUM_CH-1:0] ch_data_q;
  logic [8*NUM_CH-1:0] pub_d;
  logic                frame_valid_q;
  logic                failsafe_q;
  logic [WW-1:0]       wd_q;
`ifdef RC_SMOOTH_EN
  logic                fresh_q;
  logic [8:0]          sum;
`endif

  // Two-flop synchronizer per channel, then one register for edge detection.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= bus.pwm_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  // Free-running divider; tick is high for one cycle out of every DIV.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  assign tick = (div_q == DIV_LAST);

  // Lowest-index rising channel wins the grant; more than one riser is an overlap.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rise[i]) grant_idx = IW'(i);
    end
  end

  assign multi_rise = |(rise & (rise - NUM_CH'(1)));
  assign idx        = active_ch_q[IW-1:0];
  assign mask_full  = &mask_q;

  // Map the raw width to 0..255 after removing the 1 ms offset, and qualify the pulse.
  always_comb begin
    width_ext  = 32'(width_q);
    value_d    = 8'hFF;
    if (width_ext < 32'(OFFSET)) begin
      value_d = 8'h00;
    end else if ((width_ext - 32'(OFFSET)) < 32'd255) begin
      value_d = 8'(width_ext - 32'(OFFSET));
    end
    store_ok_d = !stuck_q && (width_ext >= 32'(MIN_TICKS));
  end

  // Sequencer: grant on a rising edge, count ticks while high, then store or discard.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      active_ch_q <= '0;
      width_q     <= '0;
      stuck_q     <= 1'b0;
      pulse_err_q <= 1'b0;
      mask_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      pulse_err_q <= 1'b0;
      if (mask_full) mask_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|rise) begin
            active_ch_q <= 3'(grant_idx);
            // The grant cycle already sees the channel high, so a tick here counts.
            width_q     <= CW'(tick);
            stuck_q     <= 1'b0;
            state_q     <= S_MEASURE;
            if (multi_rise) pulse_err_q <= 1'b1;
          end
        end
        S_MEASURE: begin
          if (fall[idx]) begin
            state_q <= S_STORE;
          end else if (tick && sync2_q[idx]) begin
            if (width_q == WIDTH_LAST) begin
              width_q <= WIDTH_MAX;
              stuck_q <= 1'b1;
              state_q <= S_STORE;
            end else begin
              width_q <= width_q + CW'(1);
            end
          end
        end
        S_STORE: begin
          if (store_ok_d) begin
            shadow_q[idx] <= value_d;
            mask_q[idx]   <= 1'b1;
          end else begin
            pulse_err_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Value published for each channel when the frame completes.
  always_comb begin
    pub_d = '0;
`ifdef RC_SMOOTH_EN
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ch_data_q[8*i +: 8]} + {1'b0, shadow_q[i]};
      // Right after reset or failsafe the published bank holds FAILSAFE_VAL, so skip averaging.
      pub_d[8*i +: 8] = fresh_q ? shadow_q[i] : sum[8:1];
    end
`else
    for (int i = 0; i < NUM_CH; i++) pub_d[8*i +: 8] = shadow_q[i];
`endif
  end

  // Publish the shadow bank once all channels are captured; otherwise age the watchdog.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ch_data_q     <= {NUM_CH{FAILSAFE_VAL}};
      frame_valid_q <= 1'b0;
      failsafe_q    <= 1'b1;
      wd_q          <= '0;
`ifdef RC_SMOOTH_EN
      fresh_q       <= 1'b1;
`endif
    end else begin
      frame_valid_q <= 1'b0;
      if (mask_full) begin
        ch_data_q     <= pub_d;
        frame_valid_q <= 1'b1;
        failsafe_q    <= 1'b0;
        wd_q          <= '0;
`ifdef RC_SMOOTH_EN
        fresh_q       <= 1'b0;
`endif
      end else if (tick && (wd_q != WD_MAX)) begin
        wd_q <= wd_q + WW'(1);
        // The counter parks at WD_MAX, so failsafe is entered exactly once per silence.
        if (wd_q == WD_LAST) begin
          failsafe_q <= 1'b1;
          ch_data_q  <= {NUM_CH{FAILSAFE_VAL}};
`ifdef RC_SMOOTH_EN
          fresh_q    <= 1'b1;
`endif
        end
      end
    end
  end

  assign bus.ch_data     = ch_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.failsafe    = failsafe_q;
  assign bus.pulse_err   = pulse_err_q;
  assign bus.active_ch   = active_ch_q;

endmodule

// File: tb/tb_rc_channel_sequencer.sv
// Bench for rc_channel_sequencer: directed and random pulse trains against a frame-level model.
// Latency: frame_valid expected 5 cycles after the last falling edge that completes a frame.
// Backpressure: none, the bench only drives pulses and observes.
module tb_rc_channel_sequencer;
  localparam int NUM_CH = 4;
  localparam int DIV    = 4;
  localparam int GAP    = 12;

  logic              sys_clk = 1'b0;
  logic              reset   = 1'b1;
  logic [NUM_CH-1:0] pwm     = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fv_cnt   = 0;
  int pe_cnt   = 0;
  int fv_cyc   = 0;
  int exp_fv   = 0;
  int exp_pe   = 0;

  int shadow_m [NUM_CH];
  int pub_m    [NUM_CH];
  int cap_m;
  bit fresh_m;

  rc_channel_sequencer_if #(.NUM_CH(NUM_CH)) bus ();
  assign bus.pwm_in = pwm;

  rc_channel_sequencer #(.NUM_CH(NUM_CH), .DIV(DIV)) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Cycle index, advanced on every active edge.
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Count output pulses away from the active edge.
  always @(negedge sys_clk) begin
    if (!reset) begin
      if (bus.frame_valid) begin
        fv_cnt++;
        fv_cyc = cyc;
      end
      if (bus.pulse_err) pe_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_val(input int ticks);
    if (ticks < 256) return 0;
    if (ticks - 256 > 255) return 255;
    return ticks - 256;
  endfunction

  function automatic logic [8*NUM_CH-1:0] exp_data();
    logic [8*NUM_CH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[8*i +: 8] = 8'(pub_m[i]);
    return v;
  endfunction

  function automatic int lowest(input logic [NUM_CH-1:0] chm);
    for (int i = 0; i < NUM_CH; i++) if (chm[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    cap_m   = 0;
    fresh_m = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_m[i] = 0;
      pub_m[i]    = 0;
    end
  endtask

  // Frame-level outcome of one pulse (possibly on several channels at once).
  task automatic model_pulse(input logic [NUM_CH-1:0] chm, input int ticks, output bit pub);
    int low;
    low = lowest(chm);
    pub = 1'b0;
    if ($countones(chm) > 1) exp_pe++;
    if (ticks < 128 || ticks >= 1023) begin
      exp_pe++;
    end else begin
      shadow_m[low] = sat_val(ticks);
      cap_m = cap_m | (1 << low);
      if (cap_m == (1 << NUM_CH) - 1) begin
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef RC_SMOOTH_EN
          pub_m[i] = fresh_m ? shadow_m[i] : (pub_m[i] + shadow_m[i]) / 2;
`else
          pub_m[i] = shadow_m[i];
`endif
        end
        fresh_m = 1'b0;
        cap_m   = 0;
        exp_fv++;
        pub     = 1'b1;
      end
    end
  endtask

  // Hold the selected channels high for exactly ticks*DIV cycles, then check the outcome.
  task automatic pulse(input logic [NUM_CH-1:0] chm, input int ticks);
    bit pub;
    int fall_c;
    @(posedge sys_clk);
    #1 pwm = pwm | chm;
    repeat (8) @(posedge sys_clk);
    #4 check("active_ch", bus.active_ch, lowest(chm));
    repeat (ticks * DIV - 8) @(posedge sys_clk);
    #1 pwm = pwm & ~chm;
    fall_c = cyc;
    model_pulse(chm, ticks, pub);
    repeat (GAP) @(posedge sys_clk);
    #4;
    check("pulse_err_count", pe_cnt, exp_pe);
    check("frame_valid_count", fv_cnt, exp_fv);
    if (pub) begin
      check("publish_latency", fv_cyc - fall_c, 5);
      check("ch_data", bus.ch_data, exp_data());
      check("failsafe_clear", bus.failsafe, 0);
    end
  endtask

  // Stop a runaway simulation with a failure instead of hanging.
  initial begin
    #1_500_000;
    n_fail++;
    $display("FAIL global_timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int e;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #4;
    check("rst_ch_data", bus.ch_data, 0);
    check("rst_failsafe", bus.failsafe, 1);
    check("rst_frame_valid", bus.frame_valid, 0);
    check("rst_pulse_err", bus.pulse_err, 0);
    check("rst_active_ch", bus.active_ch, 0);
    @(posedge sys_clk);
    #1 reset = 1'b0;

    // Basic frame: 128, 0, 255, 255.
    pulse(4'b0001, 384);
    pulse(4'b0010, 256);
    pulse(4'b0100, 512);
    pulse(4'b1000, 1000);
    check("frame1_data", bus.ch_data, 32'hFFFF_0080);

    // Glitches, including the MIN_TICKS boundary, hold back the frame.
    pulse(4'b0001, 127);
    pulse(4'b0001, 128);
    pulse(4'b0010, 150);
    pulse(4'b0100, 100);
    pulse(4'b0100, 300);
    pulse(4'b1000, 400);

    // Simultaneous rise on channels 1 and 3: channel 1 wins.
    pulse(4'b1010, 300);
    pulse(4'b0001, 400);
    pulse(4'b0100, 280);
    pulse(4'b1000, 330);
    check("overlap_ch1", bus.ch_data[15:8], 44);

    // Stuck-high channel 0 is discarded, then captured on its next pulse.
    pulse(4'b0001, 1100);
    pulse(4'b0001, 200);
    pulse(4'b0010, 200);
    pulse(4'b0100, 200);
    pulse(4'b1000, 200);

    // Silence after a publish: failsafe exactly at tick TIMEOUT_TICKS.
    e = fv_cyc;
    while (cyc < e + 6399 * DIV) @(negedge sys_clk);
    check("wd_before_timeout", bus.failsafe, 0);
    while (cyc < e + 6400 * DIV) @(negedge sys_clk);
    check("wd_timeout_failsafe", bus.failsafe, 1);
    check("wd_timeout_data", bus.ch_data, 0);
    fresh_m = 1'b1;
    for (int i = 0; i < NUM_CH; i++) pub_m[i] = 0;

    // Recovery frame publishes raw values, the next one may be smoothed.
    pulse(4'b0001, 456);
    pulse(4'b0010, 270);
    pulse(4'b0100, 280);
    pulse(4'b1000, 290);
    check("recover_ch0", bus.ch_data[7:0], 200);
    pulse(4'b0001, 356);
    pulse(4'b0010, 270);
    pulse(4'b0100, 280);
    pulse(4'b1000, 290);
`ifdef RC_SMOOTH_EN
    check("second_ch0", bus.ch_data[7:0], 150);
`else
    check("second_ch0", bus.ch_data[7:0], 100);
`endif

    // Asynchronous reset in the middle of a measurement.
    @(posedge sys_clk);
    #1 pwm = 4'b0100;
    repeat (100) @(posedge sys_clk);
    #4 check("pre_reset_active_ch", bus.active_ch, 2);
    @(posedge sys_clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_ch_data", bus.ch_data, 0);
    check("async_rst_failsafe", bus.failsafe, 1);
    check("async_rst_active_ch", bus.active_ch, 0);
    check("async_rst_frame_valid", bus.frame_valid, 0);
    pwm = '0;
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b0;
    model_reset();

    // Random frames: random channel order and widths, glitches included.
    for (int f = 0; f < 2; f++) begin
      int start_fv;
      int n;
      start_fv = exp_fv;
      n = 0;
      while (exp_fv == start_fv && n < 8) begin
        pulse(NUM_CH'(1 << $urandom_range(0, NUM_CH - 1)), int'($urandom_range(60, 300)));
        n++;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (exp_fv == start_fv && ((cap_m >> c) & 1) == 0)
          pulse(NUM_CH'(1 << c), int'($urandom_range(128, 300)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
